// File: rtl/decoder_3_to_8_pkg.sv
// -----------------------------------------------------------------------------
// decoder_3_to_8_pkg
// Width constants for the 3-to-8 one-hot decoder.
//   SEL_W : width of the binary select
//   OUT_W : width of the one-hot output
// -----------------------------------------------------------------------------
package decoder_3_to_8_pkg;

   localparam int SEL_W = 3;
   localparam int OUT_W = 8;

endpackage : decoder_3_to_8_pkg

// File: rtl/decoder_2_to_4.sv
// -----------------------------------------------------------------------------
// decoder_2_to_4
// Purely combinational enable-gated 2-to-4 one-hot decoder, built from two
// levels of enable-gated 1-to-2 decode.
//
// Ports:
//   ena      : decode enable, active-high
//   in[1:0]  : binary select
//   out[3:0] : one-hot decode of in, all zero when ena = 0
// -----------------------------------------------------------------------------
module decoder_2_to_4 (
   input  logic       ena,
   input  logic [1:0] in,
   output logic [3:0] out
);

   // Enable-gated 1-to-2 decode: bit 1 when sel = 1, bit 0 when sel = 0.
   function automatic logic [1:0] dec_1_to_2(input logic en, input logic sel);
      dec_1_to_2 = {en & sel, en & ~sel};
   endfunction

   logic [1:0] half_ena_s;

   // in[1] picks the half, in[0] picks the bit within the enabled half.
   always_comb begin
      half_ena_s = 2'b00;
      out        = 4'b0000;
      half_ena_s = dec_1_to_2(ena, in[1]);
      out        = {dec_1_to_2(half_ena_s[1], in[0]),
                    dec_1_to_2(half_ena_s[0], in[0])};
   end

endmodule : decoder_2_to_4

// File: rtl/decoder_3_to_8.sv
// -----------------------------------------------------------------------------
// decoder_3_to_8
// Enable-gated 3-to-8 one-hot decoder with a one-cycle registered copy.
//
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous reset, active-high (clears out_q / valid_q only)
//   ena     : decode enable, active-high
//   in      : binary select 0..7
//   out     : combinational one-hot decode of in, gated by ena
//   out_q   : out registered one cycle later
//   valid_q : ena registered, aligned with out_q
// -----------------------------------------------------------------------------
module decoder_3_to_8
   import decoder_3_to_8_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [SEL_W-1:0] in,
   output logic [OUT_W-1:0] out,
   output logic [OUT_W-1:0] out_q,
   output logic             valid_q
);

   logic       lo_ena_s;
   logic       hi_ena_s;
   logic [3:0] lo_out_s;
   logic [3:0] hi_out_s;

   // in[2] routes the enable to exactly one of the two 2-to-4 halves.
   assign lo_ena_s = ena & ~in[2];
   assign hi_ena_s = ena &  in[2];

   decoder_2_to_4 u_dec_lo (
      .ena (lo_ena_s),
      .in  (in[1:0]),
      .out (lo_out_s)
   );

   decoder_2_to_4 u_dec_hi (
      .ena (hi_ena_s),
      .in  (in[1:0]),
      .out (hi_out_s)
   );

   assign out = {hi_out_s, lo_out_s};

   // Output pipeline register; reset clears it but never gates the live decode.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q   <= {OUT_W{1'b0}};
         valid_q <= 1'b0;
      end else begin
         out_q   <= out;
         valid_q <= ena;
      end
   end

endmodule : decoder_3_to_8

// File: tb/tb_decoder_3_to_8.sv
// -----------------------------------------------------------------------------
// tb_decoder_3_to_8
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared against a behavioural model every cycle.
// -----------------------------------------------------------------------------
module tb_decoder_3_to_8;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [2:0] in;
   logic [7:0] out;
   logic [7:0] out_q;
   logic       valid_q;
   logic [4:0] narrow_s;

   int total = 0;
   int bad   = 0;

   localparam logic [7:0] ONEHOT_TBL [8] = '{8'h01, 8'h02, 8'h04, 8'h08,
                                             8'h10, 8'h20, 8'h40, 8'h80};

   decoder_3_to_8 dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .in      (in),
      .out     (out),
      .out_q   (out_q),
      .valid_q (valid_q)
   );

   // A 5-column consumer that only sees the low slice of out.
   assign narrow_s = out[4:0];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: the decode is the power of two selected by in, or zero when disabled.
   function automatic logic [7:0] model_out(input logic e, input logic [2:0] s);
      int unsigned v;
      v = e ? (32'd1 << s) : 32'd0;
      return v[7:0];
   endfunction

   // Cycle-by-cycle compare against the model.
   logic [7:0] m_q;
   logic       m_v;
   bit         m_known = 1'b0;

   always @(posedge clk) begin
      if (rst === 1'b1) begin
         m_q     = 8'h00;
         m_v     = 1'b0;
         m_known = 1'b1;
      end else begin
         m_q = model_out(ena, in);
         m_v = ena;
      end
      #1;
      if (m_known) begin
         check("model_out_q", out_q, m_q);
         check("model_valid_q", {7'd0, valid_q}, {7'd0, m_v});
      end
      check("model_out", out, model_out(ena, in));
      check("model_popcount", 8'($countones(out)), ena ? 8'd1 : 8'd0);
   end

   task automatic edge_then_settle();
      @(posedge clk);
      #2;
   endtask

   initial begin
      rst = 1'b1;
      ena = 1'b0;
      in  = 3'd0;
      edge_then_settle();
      edge_then_settle();
      check("reset_out_q", out_q, 8'h00);
      check("reset_valid_q", {7'd0, valid_q}, 8'h00);
      check("reset_out_comb", out, 8'h00);

      // Exhaustive enabled sweep
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         ena = 1'b1;
         in  = 3'(i);
         #1;
         check("sweep_en", out, ONEHOT_TBL[i]);
         check("sweep_en_pop", 8'($countones(out)), 8'd1);
         @(negedge clk);
      end
      in = 3'd0; ena = 1'b1; #1;
      check("boundary_in0", out, 8'h01);
      in = 3'd7; #1;
      check("boundary_in7", out, 8'h80);

      // Disabled sweep
      for (int i = 0; i < 8; i++) begin
         ena = 1'b0;
         in  = 3'(i);
         #1;
         check("sweep_dis", out, 8'h00);
         @(negedge clk);
      end

      // Pipeline timing: previous cycle was ena=0, in=7
      ena = 1'b1; in = 3'd5; #1;
      check("pipe_comb", out, 8'h20);
      check("pipe_q_before", out_q, 8'h00);
      check("pipe_v_before", {7'd0, valid_q}, 8'h00);
      edge_then_settle();
      check("pipe_q_after", out_q, 8'h20);
      check("pipe_v_after", {7'd0, valid_q}, 8'h01);

      // Reset mid-stream
      @(negedge clk);
      ena = 1'b1; in = 3'd7;
      edge_then_settle();
      check("rst_pre_q", out_q, 8'h80);
      @(negedge clk);
      rst = 1'b1; in = 3'd2; #1;
      check("rst_comb_live", out, 8'h04);
      edge_then_settle();
      check("rst_q", out_q, 8'h00);
      check("rst_v", {7'd0, valid_q}, 8'h00);
      @(negedge clk);
      rst = 1'b0;
      edge_then_settle();
      check("rst_resume_q", out_q, 8'h04);
      check("rst_resume_v", {7'd0, valid_q}, 8'h01);

      // Back-to-back toggling of ena with in = 7
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         ena = (i % 2 == 0);
         in  = 3'd7;
         edge_then_settle();
         check("toggle_q", out_q, (i % 2 == 0) ? 8'h80 : 8'h00);
         check("toggle_v", {7'd0, valid_q}, (i % 2 == 0) ? 8'h01 : 8'h00);
      end

      // Truncated consumer
      @(negedge clk);
      ena = 1'b1; in = 3'd6; #1;
      check("narrow_in6", {3'd0, narrow_s}, 8'h00);
      in = 3'd4; #1;
      check("narrow_in4", {3'd0, narrow_s}, 8'h10);

      // Randomized phase, checked by the per-cycle compare process
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         rst = ($urandom_range(15) == 0);
         ena = 1'($urandom);
         in  = 3'($urandom);
      end

      @(negedge clk);
      rst = 1'b0;
      edge_then_settle();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_decoder_3_to_8
